// File: rtl/peak_limiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_limiter_pkg
// Description : Shared types and constants for the peak limiter: FSM state
//               encoding, Q1.7 gain width and unity value, saturating gain
//               decrement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package peak_limiter_pkg;

  // Gain is Q1.7: 8 bits, 128 represents 1.0
  localparam int                GAIN_W     = 8;
  localparam int                GAIN_FRAC  = GAIN_W - 1;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'd128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Gain reduction that clamps at zero instead of wrapping
  function automatic logic [GAIN_W-1:0] gain_dec(input logic [GAIN_W-1:0] gain,
                                                 input logic [GAIN_W-1:0] step);
    return (gain > step) ? (gain - step) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/limiter_gain_mult.sv
`default_nettype none
// ============================================================================
// Module      : limiter_gain_mult
// Description : Combinational gain datapath. Scales the sample by a Q1.7
//               gain at full precision, compares against the ceiling and
//               returns the clamped sample plus the over-threshold flag.
// Revision    : 1.0 - initial release
// ============================================================================
module limiter_gain_mult
  import peak_limiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  audio_in,
  input  logic [GAIN_W-1:0] gain,
  input  logic [WIDTH-1:0]  threshold,
  output logic [WIDTH-1:0]  limited_o,
  output logic              over_o
);

  localparam int c_prod_w = WIDTH + GAIN_W;

  logic [c_prod_w-1:0]        w_prod;
  logic [c_prod_w-GAIN_FRAC-1:0] w_scaled;   // WIDTH+1 bits, keeps headroom
  logic                       w_unused_frac;

  // Both operands widened first so the product can never overflow
  assign w_prod        = c_prod_w'(audio_in) * c_prod_w'(gain);
  assign w_scaled      = w_prod[c_prod_w-1:GAIN_FRAC];
  assign w_unused_frac = ^w_prod[GAIN_FRAC-1:0];

  assign over_o    = (w_scaled > {1'b0, threshold});
  assign limited_o = over_o ? threshold : w_scaled[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/peak_limiter.sv
`default_nettype none
// ============================================================================
// Module      : peak_limiter
// Description : Sample-strobed peak limiter. Attack/hold/release gain
//               control around a multiply-and-clamp datapath; outputs are
//               registered with one ena cycle of latency.
//               Optional clip meter enabled by `define PEAK_LIMITER_METER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module peak_limiter
  import peak_limiter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ATTACK_STEP = 8,
  parameter int HOLD_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [WIDTH-1:0]  audio_in,
  input  logic [WIDTH-1:0]  threshold,
`ifdef PEAK_LIMITER_METER_EN
  input  logic              clr_meter,
`endif
  output logic [WIDTH-1:0]  audio_out,
  output logic              clip,
  output logic              limiting,
  output logic [GAIN_W-1:0] gain_out
`ifdef PEAK_LIMITER_METER_EN
  ,
  output logic [7:0]        clip_count
`endif
);

  localparam logic [GAIN_W-1:0] c_attack_step = GAIN_W'(ATTACK_STEP);
  localparam logic [7:0]        c_hold_len    = 8'(HOLD_LEN);

  state_t             state_q;
  logic [GAIN_W-1:0]  gain_q;
  logic [7:0]         hold_cnt_q;
  logic [WIDTH-1:0]   audio_out_q;
  logic               clip_q;
  logic               limiting_q;

  logic [WIDTH-1:0]   w_limited;
  logic               w_over;

  limiter_gain_mult #(
    .WIDTH (WIDTH)
  ) u_gain_mult (
    .audio_in  (audio_in),
    .gain      (gain_q),
    .threshold (threshold),
    .limited_o (w_limited),
    .over_o    (w_over)
  );

  // Gain-control FSM with registered sample, clip and limiting outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gain_q      <= GAIN_UNITY;
      hold_cnt_q  <= '0;
      audio_out_q <= '0;
      clip_q      <= 1'b0;
      limiting_q  <= 1'b0;
    end else if (ena) begin
      audio_out_q <= w_limited;
      clip_q      <= w_over;
      // An over-threshold sample always restarts the attack, whatever the state
      if (w_over) begin
        state_q    <= ATTACK;
        gain_q     <= gain_dec(gain_q, c_attack_step);
        hold_cnt_q <= '0;
        limiting_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            gain_q     <= GAIN_UNITY;
            limiting_q <= 1'b0;
          end
          ATTACK: begin
            state_q    <= HOLD;
            hold_cnt_q <= c_hold_len;
            limiting_q <= 1'b1;
          end
          HOLD: begin
            limiting_q <= 1'b1;
            if (hold_cnt_q <= 8'd1) begin
              state_q    <= RELEASE;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q - 8'd1;
            end
          end
          RELEASE: begin
            // The step that lands on unity also returns to IDLE
            if (gain_q >= GAIN_UNITY - 8'd1) begin
              gain_q     <= GAIN_UNITY;
              state_q    <= IDLE;
              limiting_q <= 1'b0;
            end else begin
              gain_q     <= gain_q + 8'd1;
              limiting_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= IDLE;
            gain_q     <= GAIN_UNITY;
            hold_cnt_q <= '0;
            limiting_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign audio_out = audio_out_q;
  assign clip      = clip_q;
  assign limiting  = limiting_q;
  assign gain_out  = gain_q;

`ifdef PEAK_LIMITER_METER_EN
  logic [7:0] clip_count_q;

  // Saturating count of clipped samples; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count_q <= '0;
    end else if (clr_meter) begin
      clip_count_q <= '0;
    end else if (ena && w_over && (clip_count_q != 8'hFF)) begin
      clip_count_q <= clip_count_q + 8'd1;
    end
  end

  assign clip_count = clip_count_q;
`endif

endmodule
`default_nettype wire
